// File: rtl/user_tlp_decoder.sv
// ---------------------------------------------------------------------------
// user_tlp_decoder
//
// Requester Completion (RC) receive path. It parses completion TLPs arriving
// on the core's 64-bit AXI-Stream RC interface and does three things:
//   - latches the completion descriptor fields,
//   - realigns the payload, which starts at DW3, into DW-aligned 64-bit words,
//   - reports the end of each completion with aggregated error status.
// This is the counterpart of the RQ encoder: it returns MemRd data to the
// controller by tag.
//
// Ports
//   user_clk, reset_n        clock; asynchronous active-low reset
//   m_axis_rc_tdata/tkeep    RC beat data / per-DW valid
//   m_axis_rc_tlast/tvalid   last beat of TLP / beat valid
//   m_axis_rc_tuser          sideband; only [42] (discontinue) is used
//   m_axis_rc_tready         ready to the core (low for the flush cycle)
//   rx_data/rx_keep          realigned payload word ([31:0] = earlier DW)
//   rx_data_valid            one-cycle strobe per payload word
//   rx_tag .. rx_req_completed  descriptor fields, held until the next TLP
//   rx_done                  one-cycle end-of-TLP strobe
//   rx_error/rx_malformed    status qualified by rx_done
// ---------------------------------------------------------------------------
module user_tlp_decoder #(
    parameter int C_DATA_WIDTH        = 64,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RC_TUSER_WIDTH = 75
) (
    input  logic                           user_clk,
    input  logic                           reset_n,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_rc_tdata,
    input  logic [KEEP_WIDTH-1:0]          m_axis_rc_tkeep,
    input  logic                           m_axis_rc_tlast,
    input  logic                           m_axis_rc_tvalid,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
    output logic                           m_axis_rc_tready,
    output logic [C_DATA_WIDTH-1:0]        rx_data,
    output logic [KEEP_WIDTH-1:0]          rx_keep,
    output logic                           rx_data_valid,
    output logic [7:0]                     rx_tag,
    output logic [11:0]                    rx_addr_low,
    output logic [12:0]                    rx_byte_count,
    output logic [10:0]                    rx_dw_count,
    output logic [2:0]                     rx_status,
    output logic                           rx_req_completed,
    output logic                           rx_done,
    output logic                           rx_error,
    output logic                           rx_malformed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR2  = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_low_q, addr_low_d;
    logic [3:0]  err_code_q, err_code_d;
    logic [12:0] byte_count_q, byte_count_d;
    logic        req_completed_q, req_completed_d;
    logic [10:0] dw_count_q, dw_count_d;
    logic [2:0]  status_q, status_d;
    logic        poisoned_q, poisoned_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] held_q, held_d;
    logic        held_valid_q, held_valid_d;
    logic [10:0] dw_rcvd_q, dw_rcvd_d;
    logic        disc_q, disc_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic [1:0]  rx_keep_q, rx_keep_d;
    logic        rx_data_valid_q, rx_data_valid_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_error_q, rx_error_d;
    logic        rx_malformed_q, rx_malformed_d;

    logic        accept;
    logic        disc_beat;
    logic        desc_err;
    logic [10:0] keep_cnt;

    // Only the discontinue bit of tuser matters; fold the rest into a sink.
    logic unused_tuser;
    assign unused_tuser = ^{m_axis_rc_tuser[AXI4_RC_TUSER_WIDTH-1:43],
                            m_axis_rc_tuser[41:0]};

    // Ready is gated by reset_n so the core sees tready = 0 while in reset.
    assign m_axis_rc_tready = reset_n && (state_q != ST_FLUSH);
    assign accept           = m_axis_rc_tvalid && m_axis_rc_tready;
    assign disc_beat        = m_axis_rc_tuser[42];
    assign keep_cnt         = {10'd0, m_axis_rc_tkeep[0]} + {10'd0, m_axis_rc_tkeep[1]};

    // Error sources fixed by the descriptor once beat 0 has been latched.
    assign desc_err = (status_q != 3'd0) || poisoned_q || (err_code_q != 4'd0);

    // NOTE: combinational next-state logic uses blocking assignments and
    // gives every variable a default first so no latch can be inferred.
    always_comb begin
        state_d         = state_q;
        addr_low_d      = addr_low_q;
        err_code_d      = err_code_q;
        byte_count_d    = byte_count_q;
        req_completed_d = req_completed_q;
        dw_count_d      = dw_count_q;
        status_d        = status_q;
        poisoned_d      = poisoned_q;
        tag_d           = tag_q;
        held_d          = held_q;
        held_valid_d    = held_valid_q;
        dw_rcvd_d       = dw_rcvd_q;
        disc_d          = disc_q;
        rx_data_d       = rx_data_q;
        rx_keep_d       = rx_keep_q;
        rx_data_valid_d = 1'b0;
        rx_done_d       = 1'b0;
        rx_error_d      = rx_error_q;
        rx_malformed_d  = rx_malformed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_low_d      = m_axis_rc_tdata[11:0];
                    err_code_d      = m_axis_rc_tdata[15:12];
                    byte_count_d    = m_axis_rc_tdata[28:16];
                    req_completed_d = m_axis_rc_tdata[30];
                    dw_count_d      = m_axis_rc_tdata[42:32];
                    status_d        = m_axis_rc_tdata[45:43];
                    poisoned_d      = m_axis_rc_tdata[46];
                    dw_rcvd_d       = 11'd0;
                    held_valid_d    = 1'b0;
                    disc_d          = disc_beat;
                    if (m_axis_rc_tlast) begin
                        // A TLP ending on its first beat has no DW2 and no tag.
                        rx_done_d      = 1'b1;
                        rx_error_d     = 1'b1;
                        rx_malformed_d = 1'b1;
                    end else begin
                        state_d = ST_HDR2;
                    end
                end
            end

            ST_HDR2: begin
                if (accept) begin
                    tag_d  = m_axis_rc_tdata[7:0];
                    disc_d = disc_q || disc_beat;
                    if (m_axis_rc_tkeep[1]) begin
                        // DW3 is the first payload DW; park it until its pair arrives.
                        held_d       = m_axis_rc_tdata[63:32];
                        held_valid_d = 1'b1;
                        dw_rcvd_d    = 11'd1;
                    end
                    if (!m_axis_rc_tlast) begin
                        state_d = ST_DATA;
                    end else if (held_valid_d) begin
                        state_d = ST_FLUSH;
                    end else begin
                        rx_done_d      = 1'b1;
                        rx_error_d     = desc_err || disc_d || (dw_rcvd_d != dw_count_q);
                        rx_malformed_d = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    disc_d    = disc_q || disc_beat;
                    dw_rcvd_d = dw_rcvd_q + keep_cnt;
                    if (m_axis_rc_tkeep != 2'b00) begin
                        rx_data_valid_d = 1'b1;
                        if (held_valid_q) begin
                            // Pair the parked DW with the low DW of this beat.
                            rx_data_d = {m_axis_rc_tdata[31:0], held_q};
                            rx_keep_d = 2'b11;
                            if (m_axis_rc_tkeep[1]) begin
                                held_d = m_axis_rc_tdata[63:32];
                            end else begin
                                held_valid_d = 1'b0;
                            end
                        end else begin
                            rx_data_d = m_axis_rc_tdata;
                            rx_keep_d = m_axis_rc_tkeep;
                        end
                    end
                    if (m_axis_rc_tlast) begin
                        if (held_valid_d) begin
                            state_d = ST_FLUSH;
                        end else begin
                            rx_done_d      = 1'b1;
                            rx_error_d     = desc_err || disc_d || (dw_rcvd_d != dw_count_q);
                            rx_malformed_d = 1'b0;
                            state_d        = ST_IDLE;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                // tready is low here, so no beat can be accepted this cycle.
                rx_data_d       = {32'h0, held_q};
                rx_keep_d       = 2'b01;
                rx_data_valid_d = 1'b1;
                rx_done_d       = 1'b1;
                rx_error_d      = desc_err || disc_q || (dw_rcvd_q != dw_count_q);
                rx_malformed_d  = 1'b0;
                held_valid_d    = 1'b0;
                state_d         = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            addr_low_q      <= '0;
            err_code_q      <= '0;
            byte_count_q    <= '0;
            req_completed_q <= 1'b0;
            dw_count_q      <= '0;
            status_q        <= '0;
            poisoned_q      <= 1'b0;
            tag_q           <= '0;
            held_q          <= '0;
            held_valid_q    <= 1'b0;
            dw_rcvd_q       <= '0;
            disc_q          <= 1'b0;
            rx_data_q       <= '0;
            rx_keep_q       <= '0;
            rx_data_valid_q <= 1'b0;
            rx_done_q       <= 1'b0;
            rx_error_q      <= 1'b0;
            rx_malformed_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_low_q      <= addr_low_d;
            err_code_q      <= err_code_d;
            byte_count_q    <= byte_count_d;
            req_completed_q <= req_completed_d;
            dw_count_q      <= dw_count_d;
            status_q        <= status_d;
            poisoned_q      <= poisoned_d;
            tag_q           <= tag_d;
            held_q          <= held_d;
            held_valid_q    <= held_valid_d;
            dw_rcvd_q       <= dw_rcvd_d;
            disc_q          <= disc_d;
            rx_data_q       <= rx_data_d;
            rx_keep_q       <= rx_keep_d;
            rx_data_valid_q <= rx_data_valid_d;
            rx_done_q       <= rx_done_d;
            rx_error_q      <= rx_error_d;
            rx_malformed_q  <= rx_malformed_d;
        end
    end

    assign rx_data          = rx_data_q;
    assign rx_keep          = rx_keep_q;
    assign rx_data_valid    = rx_data_valid_q;
    assign rx_tag           = tag_q;
    assign rx_addr_low      = addr_low_q;
    assign rx_byte_count    = byte_count_q;
    assign rx_dw_count      = dw_count_q;
    assign rx_status        = status_q;
    assign rx_req_completed = req_completed_q;
    assign rx_done          = rx_done_q;
    assign rx_error         = rx_error_q;
    assign rx_malformed     = rx_malformed_q;

endmodule
